fixed_point_add_sub_div: RTL and testbench

FIXED_POINT_ADD_SUB_DIV -- requirements
Module: fixed_point_add_sub_div

---
 rtl/fixed_point_pkg.sv | 24 ++
 rtl/fixed_point_div_core.sv | 92 +++++++++
 rtl/fixed_point_add_sub_div.sv | 149 ++++++++++++++
 tb/tb_fixed_point_add_sub_div.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point add/sub/div block.
//   op_e       : operation encoding carried on the 2-bit op port
//   sat_value  : most positive / most negative two's-complement value of a
//                w-bit word, sign-extended to MAX_W bits
package fixed_point_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_DIV     = 2'b10,
    OP_ADD_ALT = 2'b11   // reserved code, behaves as add
  } op_e;

  function automatic logic signed [MAX_W-1:0] sat_value(input int unsigned w,
                                                        input logic        is_neg);
    logic signed [MAX_W-1:0] one;
    one = 64'sd1;
    if (is_neg) return -(one <<< (w - 1));
    return (one <<< (w - 1)) - one;
  endfunction

endpackage

// File: rtl/fixed_point_div_core.sv
// Combinational signed fixed-point divide with output quantisation.
//   ina  : signed dividend, WIIA.WIFA
//   inb  : signed divisor,  WIIB.WIFB
//   quo  : signed quotient, WOI.WOF (rounded/truncated, saturated/wrapped)
//   ovf  : quotient out of range, or divide by zero
//   unf  : nonzero quotient quantised to zero
// The magnitude quotient is formed exactly to WOF+1 fractional bits
// (truncated toward zero); the extra bit drives half-LSB rounding.
module fixed_point_div_core
  import fixed_point_pkg::*;
#(
  parameter int WIIA  = 8,
  parameter int WIFA  = 8,
  parameter int WIIB  = 8,
  parameter int WIFB  = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROOF  = 1,
  parameter int ROUND = 1
) (
  input  logic signed [WIIA+WIFA-1:0] ina,
  input  logic signed [WIIB+WIFB-1:0] inb,
  output logic signed [WOI+WOF-1:0]   quo,
  output logic                        ovf,
  output logic                        unf
);

  localparam int WA     = WIIA + WIFA;
  localparam int WB     = WIIB + WIFB;
  localparam int WO     = WOI + WOF;
  // |A|/2^WIFA / (|B|/2^WIFB) scaled by 2^(WOF+1):
  //   (|A| << (WIFB+WOF+1)) / (|B| << WIFA)
  localparam int NUM_SH = WIFB + WOF + 1;
  localparam int NW     = WA + NUM_SH;
  localparam int DNW    = WB + WIFA;
  localparam int DW     = (NW > DNW) ? NW : DNW;
  localparam int CW     = ((DW > WO) ? DW : WO) + 1;

  // Drop the guard bit: half-up on the magnitude, or plain truncation.
  function automatic logic [DW-1:0] round_quo(input logic [DW-1:0] qm);
    if (ROUND != 0) return (qm + DW'(1)) >> 1;
    return qm >> 1;
  endfunction

  // Range check on the magnitude; negative results may reach 2^(WO-1).
  function automatic logic [WO:0] saturate(input logic [DW-1:0] mag,
                                           input logic          is_neg);
    logic [CW-1:0] mx;
    logic [CW-1:0] lim;
    logic [CW-1:0] v;
    mx  = CW'(mag);
    lim = (CW'(1) << (WO - 1)) - (is_neg ? CW'(0) : CW'(1));
    v   = is_neg ? (~mx + CW'(1)) : mx;
    if (mx > lim) begin
      if (ROOF != 0) return {1'b1, WO'(sat_value(WO, is_neg))};
      return {1'b1, v[WO-1:0]};
    end
    return {1'b0, v[WO-1:0]};
  endfunction

  logic [WA-1:0] mag_a;
  logic [WB-1:0] mag_b;
  logic [DW-1:0] num;
  logic [DW-1:0] den;
  logic [DW-1:0] qm;
  logic [DW-1:0] qr;
  logic          q_neg;
  logic [WO:0]   sat;

  always_comb begin
    // Two's-complement negate of the most negative word yields the correct
    // unsigned magnitude 2^(W-1).
    mag_a = ina[WA-1] ? WA'(-ina) : WA'(ina);
    mag_b = inb[WB-1] ? WB'(-inb) : WB'(inb);
    num   = DW'(mag_a) << NUM_SH;
    den   = DW'(mag_b) << WIFA;
    qm    = (den == '0) ? '0 : num / den;
    qr    = round_quo(qm);
    q_neg = ina[WA-1] ^ inb[WB-1];
    sat   = saturate(qr, q_neg);
    if (mag_b == '0) begin
      quo = WO'(sat_value(WO, ina[WA-1]));
      ovf = 1'b1;
      unf = 1'b0;
    end else begin
      quo = $signed(sat[WO-1:0]);
      ovf = sat[WO];
      unf = (mag_a != '0) && (qr == '0);
    end
  end

endmodule

// File: rtl/fixed_point_add_sub_div.sv
// Signed fixed-point add / subtract / divide with a one-cycle registered result.
//   clk, rstn          : clock, synchronous active-low reset
//   ina, inb           : operands, WIIA.WIFA and WIIB.WIFB
//   op                 : 00 add, 01 sub (A-B), 10 div (A/B), 11 add
//   in_valid           : operands and op valid this cycle
//   out                : result, WOI.WOF
//   out_valid          : in_valid delayed one cycle
//   upflow / downflow  : overflow or divide-by-zero / nonzero result lost to 0
// Result and flags update only on valid cycles and hold otherwise.
module fixed_point_add_sub_div
  import fixed_point_pkg::*;
#(
  parameter int WIIA  = 8,
  parameter int WIFA  = 8,
  parameter int WIIB  = 8,
  parameter int WIFB  = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROOF  = 1,
  parameter int ROUND = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic signed [WIIA+WIFA-1:0] ina,
  input  logic signed [WIIB+WIFB-1:0] inb,
  input  logic        [1:0]           op,
  input  logic                        in_valid,
  output logic signed [WOI+WOF-1:0]   out,
  output logic                        out_valid,
  output logic                        upflow,
  output logic                        downflow
);

  localparam int WO    = WOI + WOF;
  localparam int WI    = (WIIA > WIIB) ? WIIA : WIIB;
  localparam int WF    = (WIFA > WIFB) ? WIFA : WIFB;
  localparam int SW    = WI + WF + 1;
  localparam int SH_UP = (WOF > WF) ? WOF - WF : 0;
  localparam int SH_DN = (WF > WOF) ? WF - WOF : 0;
  // Room for the left shift plus a possible rounding carry.
  localparam int QW    = SW + SH_UP + 1;
  localparam int CW    = ((QW > WO) ? QW : WO) + 1;
  localparam logic [QW-1:0] HALF = (QW'(1) << SH_DN) >> 1;

  // Rescale the exact sum from WF to WOF fractional bits.
  function automatic logic signed [QW-1:0] round_sum(input logic signed [SW-1:0] s);
    logic signed [QW-1:0] x;
    logic        [QW-1:0] mag;
    logic                 s_neg;
    x     = QW'(s);
    s_neg = x[QW-1];
    if (ROUND != 0) begin
      mag = s_neg ? QW'(-x) : QW'(x);
      mag = (mag + HALF) >> SH_DN;
      x   = s_neg ? -$signed(mag) : $signed(mag);
    end else begin
      x = x >>> SH_DN;
    end
    return x <<< SH_UP;
  endfunction

  // {overflow, WO-bit result}: clamp when ROOF, otherwise keep the low bits.
  function automatic logic [WO:0] saturate(input logic signed [QW-1:0] q);
    logic signed [CW-1:0] qx;
    logic signed [CW-1:0] hi;
    logic signed [CW-1:0] lo;
    qx = CW'(q);
    hi = CW'(sat_value(WO, 1'b0));
    lo = CW'(sat_value(WO, 1'b1));
    if (qx > hi) return {1'b1, (ROOF != 0) ? hi[WO-1:0] : qx[WO-1:0]};
    if (qx < lo) return {1'b1, (ROOF != 0) ? lo[WO-1:0] : qx[WO-1:0]};
    return {1'b0, qx[WO-1:0]};
  endfunction

  // ---- stage p0: combinational operate and quantise ----
  logic signed [SW-1:0] a_al_p0;
  logic signed [SW-1:0] b_al_p0;
  logic signed [SW-1:0] sum_p0;
  logic signed [QW-1:0] q_p0;
  logic        [WO:0]   sat_p0;
  logic signed [WO-1:0] div_q_p0;
  logic                 div_ovf_p0;
  logic                 div_unf_p0;
  logic signed [WO-1:0] res_p0;
  logic                 upf_p0;
  logic                 dnf_p0;

  fixed_point_div_core #(
    .WIIA (WIIA),
    .WIFA (WIFA),
    .WIIB (WIIB),
    .WIFB (WIFB),
    .WOI  (WOI),
    .WOF  (WOF),
    .ROOF (ROOF),
    .ROUND(ROUND)
  ) u_div_core (
    .ina(ina),
    .inb(inb),
    .quo(div_q_p0),
    .ovf(div_ovf_p0),
    .unf(div_unf_p0)
  );

  always_comb begin
    a_al_p0 = SW'(ina) <<< (WF - WIFA);
    b_al_p0 = SW'(inb) <<< (WF - WIFB);
    sum_p0  = (op_e'(op) == OP_SUB) ? a_al_p0 - b_al_p0 : a_al_p0 + b_al_p0;
    q_p0    = round_sum(sum_p0);
    sat_p0  = saturate(q_p0);
    if (op_e'(op) == OP_DIV) begin
      res_p0 = div_q_p0;
      upf_p0 = div_ovf_p0;
      dnf_p0 = div_unf_p0;
    end else begin
      res_p0 = $signed(sat_p0[WO-1:0]);
      upf_p0 = sat_p0[WO];
      dnf_p0 = (sum_p0 != '0) && (q_p0 == '0);
    end
  end

  // ---- stage p1: output register ----
  logic signed [WO-1:0] out_p1;
  logic                 vld_p1;
  logic                 upf_p1;
  logic                 dnf_p1;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
      out_p1 <= '0;
      upf_p1 <= 1'b0;
      dnf_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        out_p1 <= res_p0;
        upf_p1 <= upf_p0;
        dnf_p1 <= dnf_p0;
      end
    end
  end

  assign out       = out_p1;
  assign out_valid = vld_p1;
  assign upflow    = upf_p1;
  assign downflow  = dnf_p1;

endmodule

// File: tb/tb_fixed_point_add_sub_div.sv
// Bench for fixed_point_add_sub_div in 8.8 formats, saturating, rounding.
module tb_fixed_point_add_sub_div;

  logic               clk = 1'b0;
  logic               rstn;
  logic signed [15:0] ina;
  logic signed [15:0] inb;
  logic        [1:0]  op;
  logic               in_valid;
  logic signed [15:0] out;
  logic               out_valid;
  logic               upflow;
  logic               downflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fixed_point_add_sub_div #(
    .WIIA (8), .WIFA (8), .WIIB (8), .WIFB (8),
    .WOI  (8), .WOF  (8), .ROOF (1), .ROUND(1)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .ina      (ina),
    .inb      (inb),
    .op       (op),
    .in_valid (in_valid),
    .out      (out),
    .out_valid(out_valid),
    .upflow   (upflow),
    .downflow (downflow)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Values in 1/256 units; the quotient is taken exactly at 1/512 and then
  // rounded half away from zero to 1/256.
  function automatic void ref_model(input logic [15:0] a, input logic [15:0] b,
                                    input logic [1:0] o, output logic [15:0] r,
                                    output logic up, output logic dn);
    longint sa, sb, q, am, bm, q512, qm;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dn = 1'b0;
    if (o == 2'b10) begin
      if (sb == 0) begin
        r  = (sa >= 0) ? 16'h7FFF : 16'h8000;
        up = 1'b1;
        return;
      end
      am   = (sa < 0) ? -sa : sa;
      bm   = (sb < 0) ? -sb : sb;
      q512 = (am * 512) / bm;
      qm   = (q512 + 1) / 2;
      q    = ((sa < 0) != (sb < 0)) ? -qm : qm;
      dn   = (sa != 0) && (qm == 0);
    end else if (o == 2'b01) begin
      q = sa - sb;
    end else begin
      q = sa + sb;
    end
    if (q > 32767) begin
      r = 16'h7FFF; up = 1'b1; dn = 1'b0;
    end else if (q < -32768) begin
      r = 16'h8000; up = 1'b1; dn = 1'b0;
    end else begin
      r = 16'(q); up = 1'b0;
    end
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] o);
    @(negedge clk);
    ina = a; inb = b; op = o; in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] o, input logic [15:0] r,
                         input logic up, input logic dn);
    issue(a, b, o);
    check({tag, ".out"}, out, r);
    check({tag, ".upflow"}, 16'(upflow), 16'(up));
    check({tag, ".downflow"}, 16'(downflow), 16'(dn));
    check({tag, ".out_valid"}, 16'(out_valid), 16'd1);
  endtask

  task automatic run_model(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [1:0] o);
    logic [15:0] r;
    logic        up, dn;
    ref_model(a, b, o, r, up, dn);
    run_vec(tag, a, b, o, r, up, dn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_out, hold_out, a, b;
    logic        exp_up, exp_dn, hold_up, hold_dn, v;
    logic [1:0]  o;

    // Reset held with valid traffic present.
    rstn = 1'b0; in_valid = 1'b1; ina = 16'h1234; inb = 16'h0101; op = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("reset.out", out, 16'h0000);
    check("reset.out_valid", 16'(out_valid), 16'd0);
    check("reset.upflow", 16'(upflow), 16'd0);
    check("reset.downflow", 16'(downflow), 16'd0);

    @(negedge clk);
    rstn = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle.out_valid", 16'(out_valid), 16'd0);

    // Directed vectors, issued back to back.
    run_vec("add1",     16'h63B3, 16'h0443, 2'b00, 16'h67F6, 1'b0, 1'b0);
    run_vec("sub1",     16'h63B3, 16'h0443, 2'b01, 16'h5F70, 1'b0, 1'b0);
    run_vec("sub2",     16'h1E65, 16'hF80D, 2'b01, 16'h2658, 1'b0, 1'b0);
    run_vec("add2",     16'h1E65, 16'hF80D, 2'b00, 16'h1672, 1'b0, 1'b0);
    run_model("sub2m",  16'h1E68, 16'hF80D, 2'b01);
    run_model("add2m",  16'h1E68, 16'hF80D, 2'b00);
    run_vec("add_ovf",  16'h9D44, 16'hCEE3, 2'b00, 16'h8000, 1'b1, 1'b0);
    run_vec("sub3",     16'h9D44, 16'hCEE3, 2'b01, 16'hCE61, 1'b0, 1'b0);
    run_vec("op11",     16'h63B3, 16'h0443, 2'b11, 16'h67F6, 1'b0, 1'b0);
    run_vec("div1",     16'h63B3, 16'h0443, 2'b10, 16'h1765, 1'b0, 1'b0);
    run_vec("div0p",    16'h0551, 16'h0000, 2'b10, 16'h7FFF, 1'b1, 1'b0);
    run_vec("div00",    16'h0000, 16'h0000, 2'b10, 16'h7FFF, 1'b1, 1'b0);
    run_vec("div0n",    16'h8000, 16'h0000, 2'b10, 16'h8000, 1'b1, 1'b0);
    run_vec("div_unf",  16'h0001, 16'h7F00, 2'b10, 16'h0000, 1'b0, 1'b1);
    run_vec("div3rd",   16'h0100, 16'h0300, 2'b10, 16'h0055, 1'b0, 1'b0);
    run_vec("div3rdn",  16'hFF00, 16'h0300, 2'b10, 16'hFFAB, 1'b0, 1'b0);
    run_vec("divhalf",  16'h0001, 16'h0200, 2'b10, 16'h0001, 1'b0, 1'b0);
    run_vec("divhalfn", 16'hFFFF, 16'h0200, 2'b10, 16'hFFFF, 1'b0, 1'b0);
    run_vec("div_ovfp", 16'h7F00, 16'h0001, 2'b10, 16'h7FFF, 1'b1, 1'b0);
    run_vec("div_ovfn", 16'h7F00, 16'hFFFF, 2'b10, 16'h8000, 1'b1, 1'b0);

    // Idle cycles: result and flags hold, out_valid drops.
    @(negedge clk); in_valid = 1'b0; ina = 16'h1111; inb = 16'h0000; op = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("hold.out", out, 16'h8000);
    check("hold.upflow", 16'(upflow), 16'd1);
    check("hold.out_valid", 16'(out_valid), 16'd0);

    // Random traffic with gaps.
    hold_out = out; hold_up = upflow; hold_dn = downflow;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 4))
        0:       b = 16'h0000;
        1:       b = 16'($urandom_range(1, 15)) ^ {16{$urandom_range(0, 1) == 1}};
        default: b = 16'($urandom);
      endcase
      a = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      o = 2'($urandom_range(0, 3));
      if (v) begin
        ref_model(a, b, o, exp_out, exp_up, exp_dn);
        hold_out = exp_out; hold_up = exp_up; hold_dn = exp_dn;
      end
      @(negedge clk);
      ina = a; inb = b; op = o; in_valid = v;
      @(posedge clk); #1;
      check("rand.out", out, hold_out);
      check("rand.upflow", 16'(upflow), 16'(hold_up));
      check("rand.downflow", 16'(downflow), 16'(hold_dn));
      check("rand.out_valid", 16'(out_valid), 16'(v));
    end

    // Reset asserted while an operation is being issued.
    @(negedge clk);
    rstn = 1'b0; in_valid = 1'b1; ina = 16'h9D44; inb = 16'hCEE3; op = 2'b00;
    @(posedge clk); #1;
    check("rst_fly.out", out, 16'h0000);
    check("rst_fly.out_valid", 16'(out_valid), 16'd0);
    check("rst_fly.upflow", 16'(upflow), 16'd0);
    check("rst_fly.downflow", 16'(downflow), 16'd0);
    @(negedge clk);
    rstn = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst.out", out, 16'h0000);
    check("post_rst.out_valid", 16'(out_valid), 16'd0);
    run_vec("post_rst.add", 16'h63B3, 16'h0443, 2'b00, 16'h67F6, 1'b0, 1'b0);

    @(negedge clk); in_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
